cpu_step_controller: RTL and testbench
======================================

// Module: cpu_step_controller
// PURPOSE
//  Sequences the single-cycle CPU on the board: decides on which clk cycles the CPU may advance.
//  Debounces the step pushbutton and reads the run switch; issues a one-cycle cpu_en pulse per step.
//  In run mode, issues cpu_en every RUN_DIV cycles; stops permanently on a CPU halt request.
//  Sits in the top level between board inputs and the CPU clock-enable; cycle_count feeds LEDs/SSD.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable clk cycles before a button level change is accepted (>=1)
//  RUN_DIV          1        run mode: one cpu_en pulse every RUN_DIV clk cycles (>=1; 1 = every cycle)
//  CNT_W            16       width of cycle_count
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  step_btn     in   1      raw pushbutton, asynchronous, bouncy
//  run_sw       in   1      raw slide switch, asynchronous; 1 = free-run
//  halt_req     in   1      level from CPU (e.g. ecall/ebreak decoded); synchronous to clk
//  cpu_en       out  1      registered; 1 = CPU commits one instruction this cycle
//  cycle_count  out  CNT_W  registered; number of cpu_en pulses issued, saturating
//  state        out  2      registered FSM state: 00 IDLE, 01 STEP, 10 RUN, 11 HALTED
// BEHAVIOUR
//  Reset: state=IDLE, cpu_en=0, cycle_count=0, synchronizers=0, debounced level=0, counters=0.
//  Sync: step_btn and run_sw each pass a 2-flop synchronizer; run_sw is not debounced.
//  Debounce: counter runs while sync step_btn != debounced level; cleared when equal.
//   When counter reaches DEBOUNCE_CYCLES-1, debounced level takes sync value, counter clears.
//  step_req: one-cycle pulse on debounced 0->1 transition; release (1->0) generates nothing.
//  FSM (evaluated each cycle; priority top to bottom):
//   IDLE:   halt_req -> HALTED; else run_sw_s -> RUN; else step_req -> STEP; else stay.
//   STEP:   cpu_en=1 this cycle only; next IDLE, or HALTED if halt_req=1.
//   RUN:    halt_req -> HALTED (no pulse that cycle); else !run_sw_s -> IDLE (div counter cleared);
//           else div counter increments; at RUN_DIV-1 cpu_en=1 and counter wraps to 0.
//   HALTED: cpu_en=0; absorbing; only rst leaves it.
//  cpu_en is high exactly in the cycles stated above, low in all others.
//  Latency: step_req in cycle N -> state=STEP and cpu_en=1 in cycle N+1 -> IDLE in N+2.
//  RUN entry: first cpu_en at the RUN_DIV-th cycle in RUN (first RUN cycle if RUN_DIV=1).
//  step_req arriving in STEP, RUN or HALTED is dropped, not queued.
//  cycle_count: +1 in every cycle with cpu_en=1; holds at all-ones (no wrap).
//  rst mid-operation: all state returns to reset values next edge regardless of state/pulse.
//  Simultaneous halt_req and run_sw/step_req: halt wins, no pulse issued.
// TESTING (bench: DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=4)
//  Single step: clean press held 10 cycles -> exactly one cpu_en pulse, state 01 for 1 cycle, count=1.
//  Bounce: toggle step_btn every 2 cycles for 12 cycles then hold high -> exactly one pulse total.
//  Run: run_sw=1 for 30 cycles -> cpu_en every 3rd cycle (9-10 pulses); run_sw=0 -> IDLE, pulses stop.
//  Halt: in RUN assert halt_req on a divider-wrap cycle -> no pulse, state=11; later steps/run ignored.
//  Saturation: 20 pulses in RUN with CNT_W=4 -> cycle_count stays at 15.
//  Reset mid-run: rst for 1 cycle while RUN -> state=00, cpu_en=0, cycle_count=0 next cycle.

Source files
------------

// File: rtl/cpu_step_controller.sv
// Board-level CPU sequencer: debounced single-step, divided free-run, and a sticky halt.
// cpu_en and state are registered together, so cpu_en is high exactly in STEP cycles and RUN wrap cycles.
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int VW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [VW-1:0] DIV_MAX = VW'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t          st, st_nxt;
  logic [1:0]      btn_sync, sw_sync;
  logic            btn_s, sw_s;
  logic [DW-1:0]   db_cnt;
  logic            db_lvl;
  logic            step_req;
  logic [VW-1:0]   div_cnt, div_nxt;
  logic            en_nxt;

  assign btn_s = btn_sync[1];
  assign sw_s  = sw_sync[1];
  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync    <= '0;
      sw_sync     <= '0;
      db_cnt      <= '0;
      db_lvl      <= 1'b0;
      step_req    <= 1'b0;
      st          <= S_IDLE;
      div_cnt     <= '0;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
    end else begin
      btn_sync <= {btn_sync[0], step_btn};
      sw_sync  <= {sw_sync[0], run_sw};
      step_req <= 1'b0;
      if (btn_s == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        // Level accepted; only the press edge requests a step.
        db_lvl   <= btn_s;
        db_cnt   <= '0;
        step_req <= btn_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      st      <= st_nxt;
      div_cnt <= div_nxt;
      cpu_en  <= en_nxt;
      if (cpu_en && !(&cycle_count))
        cycle_count <= cycle_count + 1'b1;
    end
  end

  // div_cnt holds the phase of the current RUN cycle; a pulse lands on phase RUN_DIV-1.
  always_comb begin
    st_nxt  = st;
    div_nxt = '0;
    en_nxt  = 1'b0;
    case (st)
      S_IDLE: begin
        if (halt_req) begin
          st_nxt = S_HALT;
        end else if (sw_s) begin
          st_nxt = S_RUN;
          en_nxt = (DIV_MAX == '0);
        end else if (step_req) begin
          st_nxt = S_STEP;
          en_nxt = 1'b1;
        end
      end
      S_STEP: st_nxt = halt_req ? S_HALT : S_IDLE;
      S_RUN: begin
        if (halt_req) begin
          st_nxt = S_HALT;
        end else if (!sw_s) begin
          st_nxt = S_IDLE;
        end else begin
          div_nxt = (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
          en_nxt  = (div_nxt == DIV_MAX);
        end
      end
      default: st_nxt = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed scenarios plus a random phase, checked every cycle against a cycle-level reference model.
module tb_cpu_step_controller;
  localparam int DB  = 4;
  localparam int DIV = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst, step_btn, run_sw, halt_req;
  logic          cpu_en;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state;

  cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw), .halt_req(halt_req),
    .cpu_en(cpu_en), .cycle_count(cycle_count), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: board inputs seen through 2 cycles of sync delay,
  // a stability-run counter, and a RUN-cycle ordinal for the divider.
  int m_btn_d[2], m_sw_d[2];
  int m_db, m_stable, m_req;
  int m_state, m_run, m_en, m_count;
  int pulses, step_cycles;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int req_new, st_new;
    if (rst) begin
      m_btn_d = '{0, 0}; m_sw_d = '{0, 0};
      m_db = 0; m_stable = 0; m_req = 0;
      m_state = 0; m_run = 0; m_en = 0; m_count = 0;
      return;
    end
    if (m_en != 0) m_count = (m_count < (1 << CW) - 1) ? m_count + 1 : m_count;
    req_new = 0;
    if (m_btn_d[1] != m_db) begin
      m_stable++;
      if (m_stable == DB) begin
        m_db = m_btn_d[1];
        m_stable = 0;
        req_new = m_db;
      end
    end else m_stable = 0;
    st_new = m_state;
    if (m_state == 3) st_new = 3;
    else if (halt_req) st_new = 3;
    else if (m_state == 1) st_new = 0;
    else if (m_state == 0) begin
      if (m_sw_d[1] != 0) begin st_new = 2; m_run = 1; end
      else if (m_req != 0) st_new = 1;
    end else if (m_sw_d[1] == 0) st_new = 0;
    else m_run++;
    m_state = st_new;
    m_req = req_new;
    m_en = (m_state == 1 || (m_state == 2 && m_run % DIV == 0)) ? 1 : 0;
    m_btn_d[1] = m_btn_d[0]; m_btn_d[0] = int'(step_btn);
    m_sw_d[1]  = m_sw_d[0];  m_sw_d[0]  = int'(run_sw);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cpu_en", int'(cpu_en), m_en);
    chk("state", int'(state), m_state);
    chk("cycle_count", int'(cycle_count), m_count);
    if (cpu_en) pulses++;
    if (state == 2'b01) step_cycles++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int found;
    rst = 1'b1; step_btn = 1'b0; run_sw = 1'b0; halt_req = 1'b0;
    ticks(2);
    rst = 1'b0;
    chk("reset_state", int'(state), 0);
    chk("reset_en", int'(cpu_en), 0);
    chk("reset_count", int'(cycle_count), 0);
    ticks(3);

    // Single clean press
    pulses = 0; step_cycles = 0;
    step_btn = 1'b1; ticks(10);
    step_btn = 1'b0; ticks(12);
    chk("single_pulses", pulses, 1);
    chk("single_step_cycles", step_cycles, 1);
    chk("single_count", int'(cycle_count), 1);

    // Bouncy press: 2-cycle glitches never survive the debouncer
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step_btn = ~step_btn; ticks(2);
    end
    step_btn = 1'b1; ticks(12);
    step_btn = 1'b0; ticks(12);
    chk("bounce_pulses", pulses, 1);

    // Free run for 30 cycles
    pulses = 0;
    run_sw = 1'b1; ticks(30);
    chk("run_pulses_range", int'(pulses >= 9 && pulses <= 10), 1);
    run_sw = 1'b0; ticks(4);
    pulses = 0; ticks(10);
    chk("run_stop_pulses", pulses, 0);
    chk("run_stop_state", int'(state), 0);

    // Saturation: ~22 more pulses on a 4-bit counter
    run_sw = 1'b1; ticks(68);
    run_sw = 1'b0; ticks(6);
    chk("sat_count", int'(cycle_count), 15);

    // Reset in the middle of RUN
    run_sw = 1'b1; ticks(10);
    chk("pre_reset_run", int'(state), 2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_reset_state", int'(state), 0);
    chk("mid_reset_en", int'(cpu_en), 0);
    chk("mid_reset_count", int'(cycle_count), 0);

    // Halt on the cycle that would otherwise issue a pulse
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (m_state == 2 && (m_run + 1) % DIV == 0) found = 1;
      else tick();
    end
    chk("halt_align", found, 1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("halt_no_pulse", int'(cpu_en), 0);
    chk("halt_state", int'(state), 3);
    pulses = 0;
    step_btn = 1'b1; ticks(10); step_btn = 1'b0; ticks(10);
    run_sw = 1'b0; ticks(5); run_sw = 1'b1; ticks(10);
    chk("halt_sticky_pulses", pulses, 0);
    chk("halt_sticky_state", int'(state), 3);

    // Random phase against the model
    rst = 1'b1; tick(); rst = 1'b0;
    run_sw = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5, 0) == 0) step_btn = ~step_btn;
      if ($urandom_range(24, 0) == 0) run_sw = ~run_sw;
      halt_req = ($urandom_range(59, 0) == 0);
      rst = ($urandom_range(79, 0) == 0);
      tick();
    end
    rst = 1'b0; halt_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
